// File: rtl/matrix_scanner_pkg.sv
// Shared geometry, frame layout and per-phase scan state for the 5x5 RGB scanner.
package matrix_scanner_pkg;

    localparam int N_ROWS     = 5;
    localparam int N_COLS     = 5;
    localparam int CELLS      = N_ROWS * N_COLS;
    localparam int FRAME_BITS = 3 * CELLS;
    localparam int PHASES     = 8;

    // What a row slot shows during one phase.
    typedef enum logic [1:0] {
        BLANK  = 2'd0,  // phase 0: always dark, gives drivers time to settle
        ACTIVE = 2'd1,  // phase within the duty level: row lit
        OFF    = 2'd2   // phase beyond the duty level: dark
    } phase_state_e;

    // One full frame; bit index inside each plane = row*N_COLS + col.
    typedef struct packed {
        logic [CELLS-1:0] r;
        logic [CELLS-1:0] g;
        logic [CELLS-1:0] b;
    } frame_t;

    // Classify a phase against the latched duty level (0 = dark, 7 = 7/8 duty).
    function automatic phase_state_e phase_state(input logic [2:0] ph, input logic [2:0] lvl);
        if (ph == 3'd0)    return BLANK;
        else if (ph <= lvl) return ACTIVE;
        else               return OFF;
    endfunction

endpackage

// File: rtl/matrix_scanner_tick_gen.sv
// Prescaler: free-running count 0..DIV-1, one-clock tick on the last count.
module tick_gen #(
    parameter int DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Wrap to zero on the terminal count
    always_comb begin
        cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/matrix_scanner.sv
// 5x5 RGB LED matrix scanner: row-multiplexed drive with 8-phase PWM per row,
// a holding/shadow double buffer so frames only swap at the frame boundary.
module matrix_scanner
    import matrix_scanner_pkg::*;
#(
    parameter int DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CELLS-1:0]  r_in,
    input  logic [CELLS-1:0]  g_in,
    input  logic [CELLS-1:0]  b_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic [2:0]        brightness,
    output logic [N_ROWS-1:0] row_n,
    output logic [N_COLS-1:0] col_r,
    output logic [N_COLS-1:0] col_g,
    output logic [N_COLS-1:0] col_b,
    output logic              frame_start
);

    logic tick;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    logic [2:0]        row_q, row_d;
    logic [2:0]        phase_q, phase_d;
    logic [2:0]        lvl_q, lvl_d;
    logic              full_q, full_d;
    frame_t            hold_q, hold_d;
    frame_t            shadow_q, shadow_d;
    logic [N_ROWS-1:0] row_n_q, row_n_d;
    logic [N_COLS-1:0] col_r_q, col_r_d;
    logic [N_COLS-1:0] col_g_q, col_g_d;
    logic [N_COLS-1:0] col_b_q, col_b_d;
    logic              fs_q, fs_d;
    logic              ready_q, ready_d;
    logic              row_end, boundary, accept;
    phase_state_e      state_d;

    // Scan position, brightness latch and double-buffer next state
    always_comb begin
        row_end  = tick && (phase_q == 3'(PHASES - 1));
        boundary = row_end && (row_q == 3'(N_ROWS - 1));

        phase_d = tick ? phase_q + 3'd1 : phase_q;
        row_d   = row_q;
        if (row_end) row_d = boundary ? 3'd0 : row_q + 3'd1;

        // Latched on the tick that enters phase 0 of every row slot
        lvl_d = row_end ? brightness : lvl_q;

        // At the boundary the old holding contents leave for the shadow in the
        // same edge, so an offer there is taken even though the register is
        // full; frame_ready therefore stays low across a back-to-back swap.
        accept   = frame_valid && (!full_q || boundary);
        hold_d   = accept ? frame_t'({r_in, g_in, b_in}) : hold_q;
        full_d   = accept || (full_q && !boundary);
        shadow_d = (boundary && full_q) ? hold_q : shadow_q;
    end

    // Output image for the scan position being entered on this edge
    always_comb begin
        state_d = phase_state(phase_d, lvl_d);
        row_n_d = '1;
        col_r_d = '0;
        col_g_d = '0;
        col_b_d = '0;
        if (state_d == ACTIVE) begin
            row_n_d = ~(N_ROWS'(1) << row_d);
            col_r_d = N_COLS'(shadow_d.r >> (N_COLS * int'(row_d)));
            col_g_d = N_COLS'(shadow_d.g >> (N_COLS * int'(row_d)));
            col_b_d = N_COLS'(shadow_d.b >> (N_COLS * int'(row_d)));
        end
        fs_d    = boundary;
        ready_d = !full_d;
    end

    // State and registered outputs; reset blanks the matrix and drops any pending frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            phase_q  <= '0;
            lvl_q    <= '0;
            full_q   <= 1'b0;
            hold_q   <= '0;
            shadow_q <= '0;
            row_n_q  <= '1;
            col_r_q  <= '0;
            col_g_q  <= '0;
            col_b_q  <= '0;
            fs_q     <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            row_q    <= row_d;
            phase_q  <= phase_d;
            lvl_q    <= lvl_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            shadow_q <= shadow_d;
            row_n_q  <= row_n_d;
            col_r_q  <= col_r_d;
            col_g_q  <= col_g_d;
            col_b_q  <= col_b_d;
            fs_q     <= fs_d;
            ready_q  <= ready_d;
        end
    end

    assign row_n       = row_n_q;
    assign col_r       = col_r_q;
    assign col_g       = col_g_q;
    assign col_b       = col_b_q;
    assign frame_start = fs_q;
    assign frame_ready = ready_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// Scoreboard bench for matrix_scanner at DIV=4 (row slot 32 clk, frame 160 clk).
module tb_matrix_scanner;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] r_in, g_in, b_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  brightness;
    logic [4:0]  row_n, col_r, col_g, col_b;
    logic        frame_start;

    matrix_scanner #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .brightness  (brightness),
        .row_n       (row_n),
        .col_r       (col_r),
        .col_g       (col_g),
        .col_b       (col_b),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected displayed frame: shadow contents and duty level for all rows
    typedef struct {
        logic [24:0] r;
        logic [24:0] g;
        logic [24:0] b;
        int          lvl;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_busy = 1'b0;

    logic [4:0] rn_s [160];
    logic [4:0] cr_s [160];
    logic [4:0] cg_s [160];
    logic [4:0] cb_s [160];
    logic       fs_s [160];

    // Hand-picked frames
    localparam logic [24:0] A_R = 25'h0108421;  // col 0 of every row
    localparam logic [24:0] A_G = 25'h1F00000;  // row 4 fully lit
    localparam logic [24:0] A_B = 25'h00003E0;  // row 1 fully lit
    localparam logic [24:0] B_R = 25'h1555555;
    localparam logic [24:0] B_G = 25'h0AAAAAA;
    localparam logic [24:0] B_B = 25'h1FFFFFF;
    localparam logic [24:0] C_R = 25'h0000000;
    localparam logic [24:0] C_G = 25'h00F8000;  // row 3 fully lit
    localparam logic [24:0] C_B = 25'h0000010;  // row 0 col 4

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the next frame_start; checks the number of clocks it took
    task automatic wait_fs(input string name, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 400);
        check(name, n, exp_n);
    endtask

    task automatic offer(input logic [24:0] r, input logic [24:0] g, input logic [24:0] b);
        r_in = r;
        g_in = g;
        b_in = b;
        frame_valid = 1'b1;
    endtask

    // Monitor: capture each frame from frame_start, then pop and compare
    initial begin : monitor
        exp_t       e;
        int         act [5];
        int         bad [5];
        int         n, rr, ph, fidx;
        bit         aborted, on;
        logic [4:0] er, ecr, ecg, ecb;
        fidx = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && frame_start === 1'b1) begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                fidx++;
                n = 0;
                while (n < 160 && !aborted) begin
                    if (n > 0) @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    else begin
                        rn_s[n] = row_n;
                        cr_s[n] = col_r;
                        cg_s[n] = col_g;
                        cb_s[n] = col_b;
                        fs_s[n] = frame_start;
                        n++;
                    end
                end
                if (aborted) begin
                    if (expq.size() > 0) e = expq.pop_front();
                end else if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame%0d: frame_start with no expected frame queued", fidx);
                end else begin
                    e = expq.pop_front();
                    for (int r = 0; r < 5; r++) begin
                        act[r] = 0;
                        bad[r] = 0;
                    end
                    for (int i = 0; i < 160; i++) begin
                        rr  = i / 32;
                        ph  = (i % 32) / 4;
                        on  = (ph != 0) && (ph <= e.lvl);
                        er  = on ? ~(5'd1 << rr) : 5'h1F;
                        ecr = on ? 5'(e.r >> (5 * rr)) : 5'h0;
                        ecg = on ? 5'(e.g >> (5 * rr)) : 5'h0;
                        ecb = on ? 5'(e.b >> (5 * rr)) : 5'h0;
                        if (rn_s[i] !== er || cr_s[i] !== ecr || cg_s[i] !== ecg ||
                            cb_s[i] !== ecb || (i > 0 && fs_s[i] !== 1'b0))
                            bad[rr]++;
                        if (rn_s[i] !== 5'h1F) act[rr]++;
                    end
                    for (int r = 0; r < 5; r++) begin
                        check($sformatf("frame%0d row%0d lit clocks", fidx, r), act[r], e.lvl * 4);
                        check($sformatf("frame%0d row%0d wrong samples", fidx, r), bad[r], 0);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin : stim
        int fs_at, nfs, bad;
        frame_valid = 1'b0;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        brightness = 3'd0;

        skip(3);
        check("reset row_n", row_n, 5'h1F);
        check("reset cols", {col_r, col_g, col_b}, 15'h0);
        check("reset frame_ready", frame_ready, 1'b1);
        check("reset frame_start", frame_start, 1'b0);
        rst_n = 1'b1;

        // Idle 200 clk: dark, ready, one frame_start at clock 160
        fs_at = 0; nfs = 0; bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (row_n !== 5'h1F || {col_r, col_g, col_b} !== 15'h0 || frame_ready !== 1'b1) bad++;
            if (frame_start === 1'b1) begin
                nfs++;
                fs_at = i;
                expq.push_back('{25'h0, 25'h0, 25'h0, 0});
            end
        end
        check("idle dark samples", bad, 0);
        check("idle frame_start count", nfs, 1);
        check("idle frame_start clock", fs_at, 160);

        // Frame 1, late in row 4: first frame at full brightness
        skip(100);
        brightness = 3'd7;
        offer(25'h1, 25'h0, 25'h0);
        check("offer1 ready", frame_ready, 1'b1);
        @(negedge clk);
        frame_valid = 1'b0;
        check("offer1 taken, full", frame_ready, 1'b0);
        wait_fs("frame2 start", 19);
        expq.push_back('{25'h1, 25'h0, 25'h0, 7});
        check("ready after swap", frame_ready, 1'b1);

        // Frame 2: back-to-back offers in row 0; second waits for the boundary
        skip(10);
        offer(A_R, A_G, A_B);
        check("offerA ready", frame_ready, 1'b1);
        @(negedge clk);
        offer(B_R, B_G, B_B);
        check("offerB held off", frame_ready, 1'b0);
        skip(129);
        brightness = 3'd2;
        wait_fs("frame3 start", 20);
        check("ready low after swap+accept", frame_ready, 1'b0);
        frame_valid = 1'b0;
        expq.push_back('{A_R, A_G, A_B, 2});

        // Frame 3: offer C only in the boundary clock with B still held
        skip(159);
        offer(C_R, C_G, C_B);
        wait_fs("frame4 start", 1);
        check("boundary offer keeps full", frame_ready, 1'b0);
        frame_valid = 1'b0;
        expq.push_back('{B_R, B_G, B_B, 2});

        // Frame 4: raise duty for the next frame
        skip(140);
        brightness = 3'd5;
        wait_fs("frame5 start", 20);
        expq.push_back('{C_R, C_G, C_B, 5});
        check("ready after C swap", frame_ready, 1'b1);

        // Frame 5: nothing pending, so frame 6 repeats C
        wait_fs("frame6 start", 160);
        expq.push_back('{C_R, C_G, C_B, 5});

        // Frame 6: leave D pending, then reset in row 3 phase 4
        skip(10);
        offer(25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF);
        check("offerD ready", frame_ready, 1'b1);
        @(negedge clk);
        frame_valid = 1'b0;
        skip(103);
        check("row3 phase4 lit", row_n, 5'b10111);
        check("row3 phase4 col_g", col_g, 5'h1F);
        #2 rst_n = 1'b0;
        #1;
        check("async reset row_n", row_n, 5'h1F);
        check("async reset cols", {col_r, col_g, col_b}, 15'h0);
        check("async reset frame_ready", frame_ready, 1'b1);
        check("async reset frame_start", frame_start, 1'b0);
        skip(3);
        rst_n = 1'b1;
        wait_fs("restart frame_start clock", 160);
        expq.push_back('{25'h0, 25'h0, 25'h0, 5});
        check("pending frame discarded", frame_ready, 1'b1);

        // Let the monitor finish the last frame
        begin
            int n = 0;
            while ((expq.size() != 0 || mon_busy) && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("scoreboard drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/matrix_scanner.md
MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 SHALL have parameter DIV, default 1024: clocks per PWM tick, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports r_in, g_in and b_in, each input, 25 bits: frame data; bit index = row*5 + col.
REQ-005 SHALL have port frame_valid, input, 1: producer offers r_in/g_in/b_in.
REQ-006 SHALL have port frame_ready, output, 1: holding register empty.
REQ-007 SHALL have port brightness, input, 3: global duty level 0..7, sampled at each row blank tick.
REQ-008 SHALL have port row_n, output, 5: row enables, active-low.
REQ-009 SHALL have ports col_r, col_g and col_b, each output, 5 bits: column drives, active-high.
REQ-010 SHALL have port frame_start, output, 1: one-clock pulse at start of row 0.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 and wrap; tick asserts for one clk when the count equals DIV-1.
REQ-012 Each row slot SHALL last 8 ticks, phase 0..7; phase and row advance only on tick.
REQ-013 Phase 0 SHALL be BLANK: row_n=5'b11111 and all col_*=0.
REQ-014 Phases 1..7 SHALL be ACTIVE for row r when phase <= latched brightness; otherwise outputs SHALL be as in BLANK.
REQ-015 In an ACTIVE phase: row_n[r]=0, other row_n bits=1, col_x[c]=shadow_x[r*5+c].
REQ-016 brightness SHALL be latched on the tick entering phase 0; brightness 0 SHALL give dark, 7 SHALL give 7/8 duty.
REQ-017 Row SHALL advance 0->1->2->3->4->0 on the tick after phase 7; row 4 SHALL wrap to 0.
REQ-018 All outputs SHALL be registered and SHALL change in the cycle after the tick that selects the new phase or row.
REQ-019 Handshake: transfer SHALL occur on a clk edge with frame_valid && frame_ready; the holding register then captures r_in/g_in/b_in and becomes full.
REQ-020 frame_ready SHALL equal NOT full; frame_valid while not ready SHALL be ignored, with no data captured.
REQ-021 At the frame boundary (the tick where row 4 phase 7 goes to row 0 phase 0), if the holding register is full, it SHALL copy into the shadow registers and become empty.
REQ-022 If no frame is pending at the boundary, the shadow SHALL keep its previous contents; the frame repeats.
REQ-023 If a transfer and a boundary copy occur in the same clk, the shadow SHALL take the old holding contents, the holding register SHALL take new data, and it SHALL remain full.
REQ-024 The shadow SHALL never change except at a frame boundary, so no tearing occurs mid-frame.
REQ-025 frame_start SHALL pulse for exactly one clk, coincident with the row 0 phase 0 output update.

Reset
REQ-026 While rst_n=0, all state SHALL be held cleared, independent of clk.
REQ-027 Reset values SHALL be: prescaler 0, row 0, phase 0, brightness latch 0, holding empty, shadow all 0.
REQ-028 Reset output values SHALL be: row_n=5'b11111, col_*=0, frame_ready=1, frame_start=0.
REQ-029 Reset asserted mid-frame SHALL blank outputs immediately and discard any pending frame.

Structure
REQ-030 A shared package SHALL hold N_ROWS=5, N_COLS=5, FRAME_BITS=75, PHASES=8 and the phase state encoding (BLANK, ACTIVE, OFF).
REQ-031 Prescaler SHALL be a sub-module tick_gen (params DIV; ports clk, rst_n, tick); the rest SHALL be flat.

Verification (DIV=4)
REQ-032 Release reset, then idle 200 clk -> row_n stays 5'b11111, cols 0, frame_ready=1, frame_start pulses every 160 clk.
REQ-033 Present r_in=25'h1 with brightness=7, then wait for the boundary -> row 0 active phases 1..7 (28 clk) with col_r=5'b00001 and row_n=5'b11110; phase 0 is dark for 4 clk.
REQ-034 Set brightness=2 -> exactly 8 active clk per row slot, with a 24 clk dark remainder.
REQ-035 Make two back-to-back offers within one frame -> the first is accepted, frame_ready drops, the second is held off until the boundary, and the shadow changes only at the boundary.
REQ-036 Assert frame_valid in the exact boundary clk with the holding register full -> old data enters the shadow, new data is held, and frame_ready stays 0.
REQ-037 Pulse rst_n low at row 3 phase 4 with a frame pending -> outputs go dark asynchronously, frame_ready=1, and the scan restarts at row 0.
